// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the bit serializer.
// Holds the FSM state encoding and the bit-counter width function.
package bit_serializer_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    // Counter width for a word of w bits; never below one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end with a one-word holding buffer.
// Streams words one bit per clock with no gap between words.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             last
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             accept;
    logic             out_bit;
    logic [WIDTH-1:0] sh_next;

    assign out_bit   = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
    assign sh_next   = MSB_FIRST ? (sh_q << 1) : (sh_q >> 1);
    assign din_ready = !hold_full_q;
    assign accept    = din_valid && din_ready;
    assign x_valid   = (state_q == S_SHIFT);
    assign last      = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
    assign x         = (state_q == S_SHIFT) ? out_bit : IDLE_LEVEL;

    // State registers; reset discards both the partial and the held word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sh_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state: load, shift, buffer or reload from hold at the word end.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sh_d    = din;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!last) begin
                    sh_d  = sh_next;
                    cnt_d = cnt_q + CW'(1);
                    if (accept) begin
                        hold_d      = din;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    sh_d        = hold_q;
                    cnt_d       = '0;
                    hold_full_d = 1'b0;
                end else if (accept) begin
                    sh_d  = din;
                    cnt_d = '0;
                end else begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: directed tables,
// hand-written corner sequences and a queue-based random reference.
module tb_bit_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       dv  [3];
    logic [7:0] dw  [3];
    logic       rdy [3];
    logic       xo  [3];
    logic       xv  [3];
    logic       lst [3];

    int nvec = 0;
    int nerr = 0;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_m8 (
        .clk(clk), .reset(reset), .din(dw[0]), .din_valid(dv[0]),
        .din_ready(rdy[0]), .x(xo[0]), .x_valid(xv[0]), .last(lst[0])
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_l8 (
        .clk(clk), .reset(reset), .din(dw[1]), .din_valid(dv[1]),
        .din_ready(rdy[1]), .x(xo[1]), .x_valid(xv[1]), .last(lst[1])
    );

    bit_serializer #(.WIDTH(2), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_m2 (
        .clk(clk), .reset(reset), .din(dw[2][1:0]), .din_valid(dv[2]),
        .din_ready(rdy[2]), .x(xo[2]), .x_valid(xv[2]), .last(lst[2])
    );

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: per instance, the list of bits still to appear on x,
    // each tagged with whether it ends its word. Entry 0 is on x now.
    int         wd [3];
    int         ms [3];
    logic       il [3];
    logic [1:0] mb [3][32];
    int         mn [3];

    function automatic void m_edge(input int i, input bit acc,
                                   input logic [7:0] w);
        int idx;
        if (mn[i] > 0) begin
            for (int j = 0; j < 31; j++) mb[i][j] = mb[i][j+1];
            mn[i]--;
        end
        if (acc) begin
            for (int k = 0; k < wd[i]; k++) begin
                idx = (ms[i] != 0) ? (wd[i] - 1 - k) : k;
                mb[i][mn[i]] = {w[idx], (k == wd[i] - 1) ? 1'b1 : 1'b0};
                mn[i]++;
            end
        end
    endfunction

    function automatic void m_check(input int i);
        logic ex, exv, el, er;
        exv = (mn[i] > 0);
        ex  = exv ? mb[i][0][1] : il[i];
        el  = exv ? mb[i][0][0] : 1'b0;
        er  = (mn[i] <= wd[i]);
        chk($sformatf("rnd_x[%0d]", i), 32'(xo[i]), 32'(ex));
        chk($sformatf("rnd_xv[%0d]", i), 32'(xv[i]), 32'(exv));
        chk($sformatf("rnd_last[%0d]", i), 32'(lst[i]), 32'(el));
        chk($sformatf("rnd_ready[%0d]", i), 32'(rdy[i]), 32'(er));
    endfunction

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       ex;
        logic       exv;
        logic       el;
        logic       er;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [15:0] b2b;
        bit acc [3];

        wd = '{8, 8, 2};
        ms = '{1, 0, 1};
        il = '{1'b0, 1'b1, 1'b0};
        mn = '{0, 0, 0};

        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dv[i] = 1'b0;
            dw[i] = 8'h00;
        end
        #12;
        chk("rst_x", 32'(xo[0]), 32'd0);
        chk("rst_xv", 32'(xv[0]), 32'd0);
        chk("rst_last", 32'(lst[0]), 32'd0);
        chk("rst_ready", 32'(rdy[0]), 32'd1);
        chk("rst_idle_hi", 32'(xo[1]), 32'd1);
        reset = 1'b0;
        step();

        // Single word 1011_0110, MSB first, then idle.
        tbl[0] = '{1'b1, 8'hB6, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            dv[0] = tbl[i].v;
            dw[0] = tbl[i].d;
            step();
            chk($sformatf("tbl_x[%0d]", i), 32'(xo[0]), 32'(tbl[i].ex));
            chk($sformatf("tbl_xv[%0d]", i), 32'(xv[0]), 32'(tbl[i].exv));
            chk($sformatf("tbl_last[%0d]", i), 32'(lst[0]), 32'(tbl[i].el));
            chk($sformatf("tbl_ready[%0d]", i), 32'(rdy[0]), 32'(tbl[i].er));
        end

        // Back-to-back A5 then 3C with valid held high.
        b2b = 16'hA53C;
        dv[0] = 1'b1;
        dw[0] = 8'hA5;
        for (int i = 0; i < 16; i++) begin
            step();
            if (i == 0) dw[0] = 8'h3C;
            if (i == 1) dv[0] = 1'b0;
            chk($sformatf("b2b_x[%0d]", i), 32'(xo[0]), 32'(b2b[15-i]));
            chk($sformatf("b2b_xv[%0d]", i), 32'(xv[0]), 32'd1);
            chk($sformatf("b2b_last[%0d]", i), 32'(lst[0]),
                32'((i == 7) || (i == 15)));
            chk($sformatf("b2b_ready[%0d]", i), 32'(rdy[0]),
                32'(!((i >= 1) && (i <= 7))));
        end
        step();
        chk("b2b_idle", 32'(xv[0]), 32'd0);

        // LSB-first 8'h01: a single one then seven zeros, idle high.
        dv[1] = 1'b1;
        dw[1] = 8'h01;
        for (int i = 0; i < 8; i++) begin
            step();
            dv[1] = 1'b0;
            chk($sformatf("lsb_x[%0d]", i), 32'(xo[1]), 32'(i == 0));
            chk($sformatf("lsb_last[%0d]", i), 32'(lst[1]), 32'(i == 7));
        end
        step();
        chk("lsb_idle_xv", 32'(xv[1]), 32'd0);
        chk("lsb_idle_x", 32'(xo[1]), 32'd1);

        // Asynchronous reset mid-word with a second word held.
        dv[0] = 1'b1;
        dw[0] = 8'hFF;
        step();
        step();
        dv[0] = 1'b0;
        step();
        chk("ar_pre_ready", 32'(rdy[0]), 32'd0);
        chk("ar_pre_x", 32'(xo[0]), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_x", 32'(xo[0]), 32'd0);
        chk("ar_xv", 32'(xv[0]), 32'd0);
        chk("ar_ready", 32'(rdy[0]), 32'd1);
        step();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("ar_post_xv[%0d]", i), 32'(xv[0]), 32'd0);
        end

        // WIDTH=2: 10, then 01 accepted on the last cycle, no gap.
        dv[2] = 1'b1;
        dw[2] = 8'h02;
        step();
        dv[2] = 1'b0;
        chk("w2_x0", 32'(xo[2]), 32'd1);
        chk("w2_l0", 32'(lst[2]), 32'd0);
        step();
        chk("w2_x1", 32'(xo[2]), 32'd0);
        chk("w2_l1", 32'(lst[2]), 32'd1);
        chk("w2_r1", 32'(rdy[2]), 32'd1);
        dv[2] = 1'b1;
        dw[2] = 8'h01;
        step();
        dv[2] = 1'b0;
        chk("w2_x2", 32'(xo[2]), 32'd0);
        chk("w2_xv2", 32'(xv[2]), 32'd1);
        chk("w2_l2", 32'(lst[2]), 32'd0);
        chk("w2_r2", 32'(rdy[2]), 32'd1);
        step();
        chk("w2_x3", 32'(xo[2]), 32'd1);
        chk("w2_l3", 32'(lst[2]), 32'd1);
        chk("w2_r3", 32'(rdy[2]), 32'd1);
        step();
        chk("w2_idle", 32'(xv[2]), 32'd0);

        // Random traffic on all three instances against the model.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 3; i++) begin
                dv[i]  = ($urandom_range(0, 9) < 6);
                dw[i]  = 8'($urandom);
                acc[i] = dv[i] && (mn[i] <= wd[i]);
            end
            step();
            for (int i = 0; i < 3; i++) begin
                m_edge(i, acc[i], dw[i]);
                m_check(i);
            end
        end
        for (int i = 0; i < 3; i++) dv[i] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                m_edge(i, 1'b0, 8'h00);
                m_check(i);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
